// File: rtl/ssr_multi_memory_compare.sv
// Single-shot-readout drift guard: photon counts in N_MEM rotating memories, memory 0 vs rest.
// Optional margin input port and compare threshold enabled by defining SSR_MARGIN_EN.
module ssr_multi_memory_compare #(
    parameter int N_MEM       = 2,
    parameter int CNT_W       = 24,
    parameter int SYNC_STAGES = 2,
    localparam int IDX_W      = $clog2(N_MEM)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             photon,
    input  logic             swap,
    input  logic             ssr,
    input  logic             readout,
    input  logic             clear,
`ifdef SSR_MARGIN_EN
    input  logic [CNT_W-1:0] margin,
`endif
    output logic             flip,
    output logic             flip_valid,
    output logic [IDX_W-1:0] winner,
    output logic [IDX_W-1:0] cur_mem,
    output logic             busy,
    output logic             overflow
);

    localparam int NIN        = 5;
    localparam int IN_PHOTON  = 0;
    localparam int IN_SWAP    = 1;
    localparam int IN_SSR     = 2;
    localparam int IN_READOUT = 3;
    localparam int IN_CLEAR   = 4;

    typedef enum logic [1:0] {StIdle, StCompare, StDone} state_e;

    logic [NIN-1:0]                  raw;
    logic [NIN-1:0][SYNC_STAGES-1:0] sync_q;
    logic [NIN-1:0]                  prev_q;
    logic [NIN-1:0]                  synced;
    logic [NIN-1:0]                  stb;

    assign raw = {clear, readout, ssr, swap, photon};

    always_comb begin
        for (int i = 0; i < NIN; i++) begin
            synced[i] = sync_q[i][SYNC_STAGES-1];
        end
    end

    assign stb = synced & ~prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            for (int i = 0; i < NIN; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw[i]};
            end
            prev_q <= synced;
        end
    end

    state_e           state_q, state_d;
    logic [CNT_W-1:0] mem_q [N_MEM];
    logic [CNT_W-1:0] mem_d [N_MEM];
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] best_q, best_d;
    logic [IDX_W-1:0] best_idx_q, best_idx_d;
    logic             ref_win_q, ref_win_d;
    logic             flip_q, flip_d;
    logic [IDX_W-1:0] winner_q, winner_d;
    logic             flip_valid_q, flip_valid_d;
    logic             overflow_q, overflow_d;
    logic [IDX_W-1:0] cur_mem_q, cur_mem_d;
    logic [CNT_W-1:0] margin_eff;
    logic [CNT_W:0]   cur_ext, ref_ext, thr_ext;

`ifdef SSR_MARGIN_EN
    logic [CNT_W-1:0] margin_q, margin_d;
    assign margin_eff = margin_q;
`else
    assign margin_eff = '0;
`endif

    // One extra bit so mem[i] + margin can never wrap.
    assign cur_ext = {1'b0, mem_q[idx_q]};
    assign ref_ext = {1'b0, mem_q[0]};
    assign thr_ext = cur_ext + {1'b0, margin_eff};

    always_comb begin
        state_d      = state_q;
        mem_d        = mem_q;
        idx_d        = idx_q;
        best_d       = best_q;
        best_idx_d   = best_idx_q;
        ref_win_d    = ref_win_q;
        flip_d       = flip_q;
        winner_d     = winner_q;
        flip_valid_d = 1'b0;
        overflow_d   = overflow_q;
        cur_mem_d    = cur_mem_q;
`ifdef SSR_MARGIN_EN
        margin_d     = margin_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (stb[IN_READOUT]) begin
                    state_d    = StCompare;
                    idx_d      = IDX_W'(1);
                    best_d     = mem_q[0];
                    best_idx_d = '0;
                    ref_win_d  = 1'b1;
`ifdef SSR_MARGIN_EN
                    margin_d   = margin;
`endif
                end
            end
            StCompare: begin
                if (cur_ext > {1'b0, best_q}) begin
                    best_d     = mem_q[idx_q];
                    best_idx_d = idx_q;
                end
                if (!(ref_ext > thr_ext)) begin
                    ref_win_d = 1'b0;
                end
                if (idx_q == IDX_W'(N_MEM - 1)) begin
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone: begin
                flip_d       = ref_win_q;
                winner_d     = best_idx_q;
                flip_valid_d = 1'b1;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Counts freeze from the readout strobe onward so memory 0 is stable during compare.
        if (state_q == StIdle && stb[IN_PHOTON] && !stb[IN_READOUT] && !stb[IN_SSR]) begin
            if (mem_q[cur_mem_q] == '1) begin
                overflow_d = 1'b1;
            end else begin
                mem_d[cur_mem_q] = mem_q[cur_mem_q] + 1'b1;
            end
        end

        if (stb[IN_SWAP]) begin
            cur_mem_d = (cur_mem_q == IDX_W'(N_MEM - 1)) ? '0 : cur_mem_q + 1'b1;
        end

        if (stb[IN_CLEAR]) begin
            flip_d = 1'b0;
        end

        if (stb[IN_SSR]) begin
            for (int m = 0; m < N_MEM; m++) begin
                mem_d[m] = '0;
            end
            overflow_d = 1'b0;
            cur_mem_d  = IDX_W'(N_MEM - 1);
            if (state_q != StDone) begin
                state_d = StIdle;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            mem_q        <= '{default: '0};
            idx_q        <= '0;
            best_q       <= '0;
            best_idx_q   <= '0;
            ref_win_q    <= 1'b0;
            flip_q       <= 1'b0;
            winner_q     <= '0;
            flip_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            cur_mem_q    <= IDX_W'(N_MEM - 1);
`ifdef SSR_MARGIN_EN
            margin_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            mem_q        <= mem_d;
            idx_q        <= idx_d;
            best_q       <= best_d;
            best_idx_q   <= best_idx_d;
            ref_win_q    <= ref_win_d;
            flip_q       <= flip_d;
            winner_q     <= winner_d;
            flip_valid_q <= flip_valid_d;
            overflow_q   <= overflow_d;
            cur_mem_q    <= cur_mem_d;
`ifdef SSR_MARGIN_EN
            margin_q     <= margin_d;
`endif
        end
    end

    assign flip       = flip_q;
    assign flip_valid = flip_valid_q;
    assign winner     = winner_q;
    assign cur_mem    = cur_mem_q;
    assign busy       = (state_q == StCompare);
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_ssr_multi_memory_compare.sv
// Directed bench for ssr_multi_memory_compare (N_MEM=4, CNT_W=4); margin cases under SSR_MARGIN_EN.
module tb_ssr_multi_memory_compare;

    localparam int N_MEM       = 4;
    localparam int CNT_W       = 4;
    localparam int SYNC_STAGES = 2;
    localparam int IDX_W       = 2;
    // Negedges from readout rise to first flip_valid sample: sync, strobe edge, N_MEM, register.
    localparam int LAT         = SYNC_STAGES + N_MEM + 1;

    localparam logic [4:0] P_PHOTON = 5'b00001;
    localparam logic [4:0] P_SWAP   = 5'b00010;
    localparam logic [4:0] P_SSR    = 5'b00100;
    localparam logic [4:0] P_READ   = 5'b01000;
    localparam logic [4:0] P_CLEAR  = 5'b10000;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic photon = 1'b0, swap = 1'b0, ssr = 1'b0, readout = 1'b0, clear = 1'b0;
`ifdef SSR_MARGIN_EN
    logic [CNT_W-1:0] margin = '0;
`endif
    logic             flip, flip_valid, busy, overflow;
    logic [IDX_W-1:0] winner, cur_mem;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ssr_multi_memory_compare #(
        .N_MEM      (N_MEM),
        .CNT_W      (CNT_W),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .photon    (photon),
        .swap      (swap),
        .ssr       (ssr),
        .readout   (readout),
        .clear     (clear),
`ifdef SSR_MARGIN_EN
        .margin    (margin),
`endif
        .flip      (flip),
        .flip_valid(flip_valid),
        .winner    (winner),
        .cur_mem   (cur_mem),
        .busy      (busy),
        .overflow  (overflow)
    );

    typedef struct {
        string      name;
        int         c0, c1, c2, c3;
        logic       flip;
        logic [1:0] win;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic drive(input logic [4:0] bits);
        {clear, readout, ssr, swap, photon} = bits;
    endtask

    // Called at a negedge; high 3 cycles, low 3 cycles.
    task automatic pulse(input logic [4:0] bits);
        drive(bits);
        repeat (3) @(negedge clk);
        drive(5'b0);
        repeat (3) @(negedge clk);
    endtask

    task automatic load_counts(input int c0, input int c1, input int c2, input int c3);
        int c [4];
        c = '{c0, c1, c2, c3};
        pulse(P_SSR);
        for (int m = 0; m < 4; m++) begin
            pulse(P_SWAP);
            repeat (c[m]) pulse(P_PHOTON);
        end
    endtask

    // Readout with an optional extra input pulse starting extra_at negedges after the readout rise.
    task automatic do_readout(input string tag, input logic [4:0] extra, input int extra_at,
                              input bit exp_valid, input logic exp_flip,
                              input logic [1:0] exp_win);
        int         first;
        int         pulses;
        logic       f;
        logic [1:0] w;
        first  = -1;
        pulses = 0;
        f      = 1'b0;
        w      = '0;
        for (int s = 0; s < 20; s++) begin
            drive(((s < 3) ? P_READ : 5'b0) |
                  ((s >= extra_at && s < extra_at + 3) ? extra : 5'b0));
            @(negedge clk);
            if (flip_valid === 1'b1) begin
                pulses++;
                if (first < 0) begin
                    first = s + 1;
                    f     = flip;
                    w     = winner;
                end
            end
        end
        drive(5'b0);
        @(negedge clk);
        if (exp_valid) begin
            check({tag, "_valid_pulses"}, pulses, 1);
            check({tag, "_latency"}, first, LAT);
            check({tag, "_flip"}, f, exp_flip);
            check({tag, "_winner"}, w, exp_win);
        end else begin
            check({tag, "_no_valid"}, pulses, 0);
        end
        check({tag, "_busy_after"}, busy, 0);
    endtask

    initial begin
        vecs[0] = '{"n2_5v3",    5, 3, 0, 0, 1'b1, 2'd0};
        vecs[1] = '{"n2_3v5",    3, 5, 0, 0, 1'b0, 2'd1};
        vecs[2] = '{"n4_7729",   7, 7, 2, 9, 1'b0, 2'd3};
        vecs[3] = '{"n4_tie",    7, 7, 2, 1, 1'b0, 2'd0};
        vecs[4] = '{"n4_8721",   8, 7, 2, 1, 1'b1, 2'd0};
        vecs[5] = '{"all_zero",  0, 0, 0, 0, 1'b0, 2'd0};
        vecs[6] = '{"low_idx",   2, 0, 3, 3, 1'b0, 2'd2};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_flip", flip, 0);
        check("rst_flip_valid", flip_valid, 0);
        check("rst_winner", winner, 0);
        check("rst_busy", busy, 0);
        check("rst_overflow", overflow, 0);
        check("rst_cur_mem", cur_mem, N_MEM - 1);
        reset_n = 1'b1;
        @(negedge clk);

        // Reset in the middle of counting
        pulse(P_SSR);
        check("ssr_cur_mem", cur_mem, N_MEM - 1);
        pulse(P_SWAP);
        check("swap_cur_mem", cur_mem, 0);
        repeat (2) pulse(P_PHOTON);
        reset_n = 1'b0;
        #1;
        check("midrst_cur_mem", cur_mem, N_MEM - 1);
        check("midrst_flip", flip, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        load_counts(3, 0, 0, 0);
        do_readout("after_rst", 5'b0, 99, 1'b1, 1'b1, 2'd0);

        // Table-driven compare vectors
        for (int v = 0; v < 7; v++) begin
            load_counts(vecs[v].c0, vecs[v].c1, vecs[v].c2, vecs[v].c3);
            check({vecs[v].name, "_cur_mem"}, cur_mem, N_MEM - 1);
            do_readout(vecs[v].name, 5'b0, 99, 1'b1, vecs[v].flip, vecs[v].win);
        end

        // Photon and swap in the same cycle count into the old memory
        pulse(P_SSR);
        pulse(P_SWAP);
        pulse(P_PHOTON | P_SWAP);
        check("ph_swap_cur_mem", cur_mem, 1);
        do_readout("ph_swap", 5'b0, 99, 1'b1, 1'b1, 2'd0);

        // Photon during compare is dropped
        load_counts(3, 2, 0, 0);
        pulse(P_SWAP);
        pulse(P_SWAP);
        check("busy_ph_cur_mem", cur_mem, 1);
        do_readout("busy_ph1", P_PHOTON, 1, 1'b1, 1'b1, 2'd0);
        do_readout("busy_ph2", 5'b0, 99, 1'b1, 1'b1, 2'd0);

        // ssr during compare aborts with no result update
        load_counts(2, 5, 0, 0);
        do_readout("pre_abort", 5'b0, 99, 1'b1, 1'b0, 2'd1);
        load_counts(6, 1, 0, 0);
        do_readout("abort", P_SSR, 1, 1'b0, 1'b0, 2'd0);
        check("abort_flip", flip, 0);
        check("abort_winner", winner, 1);
        check("abort_cur_mem", cur_mem, N_MEM - 1);

        // clear landing on DONE wins over the new decision
        load_counts(6, 1, 0, 0);
        do_readout("clr_done", P_CLEAR, 4, 1'b1, 1'b0, 2'd0);
        check("clr_done_flip_hold", flip, 0);

        // plain clear after a winning readout
        load_counts(6, 1, 0, 0);
        do_readout("pre_clr", 5'b0, 99, 1'b1, 1'b1, 2'd0);
        pulse(P_CLEAR);
        check("clr_flip", flip, 0);
        check("clr_winner", winner, 0);

        // Saturation at 15 and sticky overflow
        pulse(P_SSR);
        pulse(P_SWAP);
        repeat (15) pulse(P_PHOTON);
        check("ovf_at_15", overflow, 0);
        repeat (5) pulse(P_PHOTON);
        check("ovf_set", overflow, 1);
        pulse(P_SWAP);
        repeat (15) pulse(P_PHOTON);
        do_readout("sat_tie", 5'b0, 99, 1'b1, 1'b0, 2'd0);
        check("ovf_sticky", overflow, 1);
        pulse(P_SSR);
        check("ovf_cleared", overflow, 0);

`ifdef SSR_MARGIN_EN
        margin = 4'd3;
        load_counts(10, 7, 0, 0);
        do_readout("margin_10v7", 5'b0, 99, 1'b1, 1'b0, 2'd0);
        load_counts(11, 7, 0, 0);
        do_readout("margin_11v7", 5'b0, 99, 1'b1, 1'b1, 2'd0);
        margin = '0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
